// File: rtl/alu2_share_pkg.sv
// Shared constants and pipeline payload types for the alu2 sharing controller.
package alu2_share_pkg;

    localparam int unsigned IW       = 10;
    localparam int unsigned OW       = 6;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NREQ_MAX = 8;

    // Requester index, sized for the largest supported NREQ.
    typedef logic [$clog2(NREQ_MAX)-1:0] req_id_t;

    // Contents of one pipeline stage.
    typedef struct packed {
        logic          vld;
        logic [IW-1:0] op;
        req_id_t       id;
    } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    // Rotate the search origin to ptr and take the first valid requester.
    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (en && !any && req[IDW'(idx)]) begin
                gnt[IDW'(idx)] = 1'b1;
                gnt_idx        = IDW'(idx);
                any            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu2_share_ctrl.sv
// Round-robin front end sharing one external alu2_cl among NREQ requesters.
module alu2_share_ctrl #(
    parameter int unsigned NREQ = alu2_share_pkg::NREQ_DEF,
    parameter int unsigned IW   = alu2_share_pkg::IW,
    parameter int unsigned OW   = alu2_share_pkg::OW,
    parameter int unsigned CW   = 16,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*IW-1:0]   req_data,
    output logic [IW-1:0]        alu_in,
    input  logic [OW-1:0]        alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OW-1:0]        rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [CW-1:0]        op_count
);

    import alu2_share_pkg::*;

    stage_t         iss_q, iss_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [OW-1:0]  rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  op_count_q, op_count_d;

    logic            rsp_adv, iss_adv, arb_en;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [IW-1:0]   gnt_op;

    // Stage advance conditions; arbitration is suppressed during reset.
    always_comb begin
        rsp_adv = !rsp_valid_q || rsp_ready;
        iss_adv = !iss_q.vld || rsp_adv;
        arb_en  = iss_adv && !rst;
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // One-hot select of the granted operand vector.
    always_comb begin
        gnt_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_op = gnt_op | req_data[i*IW +: IW];
            end
        end
    end

    // Next-state for pipeline, pointer and counter; registers hold by default.
    always_comb begin
        iss_d       = iss_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        op_count_d  = op_count_q;

        if (rsp_adv) begin
            rsp_valid_d = iss_q.vld;
            if (iss_q.vld) begin
                rsp_data_d = alu_out;
                rsp_id_d   = IDW'(iss_q.id);
            end
        end

        // op/id keep their last value on a bubble so alu_in stays quiet.
        if (iss_adv) begin
            iss_d.vld = gnt_any;
            if (gnt_any) begin
                iss_d.op = gnt_op;
                iss_d.id = $bits(req_id_t)'(gnt_idx);
            end
        end

        if (gnt_any) begin
            ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : IDW'(32'(gnt_idx) + 1);
            if (op_count_q != '1) begin
                op_count_d = op_count_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
            op_count_q  <= '0;
        end else begin
            iss_q       <= iss_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign req_ready = gnt;
    assign alu_in    = iss_q.op;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = iss_q.vld || rsp_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu2_share_ctrl.sv
// Bench for alu2_share_ctrl: directed phases plus random traffic against a transaction model.
module tb_alu2_share_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [39:0] req_data;
    logic        rsp_ready;

    logic [3:0]  req_ready, req_ready_s;
    logic [9:0]  alu_in, alu_in_s;
    logic [5:0]  alu_out, alu_out_s;
    logic        rsp_valid, rsp_valid_s;
    logic [5:0]  rsp_data, rsp_data_s;
    logic [1:0]  rsp_id, rsp_id_s;
    logic        busy, busy_s;
    logic [15:0] op_count;
    logic [3:0]  op_count_s;

    int checks = 0;
    int errors = 0;

    // Stand-in for the external alu2_cl: any fixed combinational 10->6 map.
    function automatic logic [5:0] alu_model(input logic [9:0] x);
        logic [5:0] s;
        s = 6'({1'b0, x[9:5]}) + 6'({1'b0, x[4:0]});
        return s ^ {x[2], x[7:3]};
    endfunction

    assign alu_out   = alu_model(alu_in);
    assign alu_out_s = alu_model(alu_in_s);

    alu2_share_ctrl #(.NREQ(4), .IW(10), .OW(6), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .alu_in(alu_in), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    alu2_share_ctrl #(.NREQ(4), .IW(10), .OW(6), .CW(4)) u_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_data(req_data), .alu_in(alu_in_s), .alu_out(alu_out_s),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_data(rsp_data_s),
        .rsp_id(rsp_id_s), .busy(busy_s), .op_count(op_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one slot per pipeline stage, plus pointer and counters.
    bit         m_iss_v, m_rsp_v;
    logic [9:0] m_iss_op;
    int         m_iss_id, m_rsp_id, m_ptr, m_cnt;
    logic [5:0] m_rsp_data;
    int         accepted, delivered;

    logic [3:0]  obs_gnt;
    logic [9:0]  obs_alu;
    logic        obs_rv, obs_busy;
    logic [1:0]  obs_rid;
    logic [5:0]  obs_rdata;
    logic [15:0] obs_cnt;
    logic [3:0]  obs_cnt_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_iss_v = 0; m_rsp_v = 0; m_iss_op = '0; m_iss_id = 0;
        m_rsp_data = '0; m_rsp_id = 0; m_ptr = 0; m_cnt = 0;
        accepted = 0; delivered = 0;
    endtask

    // One clock cycle: inputs already applied; check, update model, advance.
    task automatic step();
        bit         radv, iadv;
        int         g;
        logic [3:0] exp_gnt;
        int         exp_cnt, exp_cnt_s;
        #1;
        radv = !m_rsp_v || rsp_ready;
        iadv = !m_iss_v || radv;
        g = -1;
        if (!rst && iadv) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_gnt   = (g >= 0) ? 4'(1 << g) : 4'b0000;
        exp_cnt   = (m_cnt > 65535) ? 65535 : m_cnt;
        exp_cnt_s = (m_cnt > 15) ? 15 : m_cnt;

        obs_gnt = req_ready; obs_alu = alu_in; obs_rv = rsp_valid; obs_busy = busy;
        obs_rid = rsp_id; obs_rdata = rsp_data; obs_cnt = op_count; obs_cnt_s = op_count_s;

        chk("req_ready", 32'(req_ready), 32'(exp_gnt));
        chk("alu_in",    32'(alu_in),    32'(m_iss_op));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        chk("rsp_data",  32'(rsp_data),  32'(m_rsp_data));
        chk("rsp_id",    32'(rsp_id),    32'(m_rsp_id));
        chk("busy",      32'(busy),      32'(m_iss_v || m_rsp_v));
        chk("op_count",  32'(op_count),  32'(exp_cnt));
        chk("sat_req_ready", 32'(req_ready_s), 32'(exp_gnt));
        chk("sat_rsp_valid", 32'(rsp_valid_s), 32'(m_rsp_v));
        chk("sat_rsp_data",  32'(rsp_data_s),  32'(m_rsp_data));
        chk("sat_op_count",  32'(op_count_s),  32'(exp_cnt_s));

        if (rst) begin
            model_reset();
        end else begin
            if (m_rsp_v && rsp_ready) delivered++;
            if (radv) begin
                if (m_iss_v) begin
                    m_rsp_data = alu_model(m_iss_op);
                    m_rsp_id   = m_iss_id;
                end
                m_rsp_v = m_iss_v;
            end
            if (iadv) begin
                m_iss_v = (g >= 0);
                if (g >= 0) begin
                    m_iss_op = req_data[g*10 +: 10];
                    m_iss_id = g;
                    m_ptr    = (g + 1) % 4;
                    m_cnt++;
                    accepted++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rr_seen [6];
        logic [3:0] rr_exp  [6];
        int         nbp;

        rst = 1'b1; req_valid = 4'hF; req_data = '0; rsp_ready = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Reset with every requester valid.
        repeat (2) step();
        chk("reset_busy", 32'(obs_busy), 32'd0);
        chk("reset_gnt",  32'(obs_gnt),  32'd0);

        // Single operation from requester 1.
        rst = 1'b0; req_valid = 4'b0010; req_data = {$urandom, $urandom};
        req_data[19:10] = 10'h3A5;
        step();
        chk("single_gnt", 32'(obs_gnt), 32'h2);
        req_valid = 4'b0000;
        step();
        chk("single_alu_in", 32'(obs_alu), 32'h3A5);
        step();
        chk("single_rsp_valid", 32'(obs_rv),    32'd1);
        chk("single_rsp_id",    32'(obs_rid),   32'd1);
        chk("single_rsp_data",  32'(obs_rdata), 32'(alu_model(10'h3A5)));
        chk("single_count",     32'(obs_cnt),   32'd1);

        // Round robin over requesters 0, 2, 3 starting from pointer 0.
        rst = 1'b1; step();
        rst = 1'b0; req_valid = 4'b1101;
        rr_exp = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            req_data = {$urandom, $urandom};
            step();
            rr_seen[i] = obs_gnt;
        end
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(rr_seen[i]), 32'(rr_exp[i]));
        req_valid = 4'b0000;
        repeat (3) step();

        // Backpressure: five stalled cycles with everyone requesting.
        req_valid = 4'hF; rsp_ready = 1'b0; nbp = 0;
        for (int i = 0; i < 5; i++) begin
            req_data = {$urandom, $urandom};
            step();
            nbp += $countones(obs_gnt);
        end
        chk("bp_grants", 32'(nbp), 32'd2);
        req_valid = 4'b0000; rsp_ready = 1'b1;
        repeat (4) step();
        chk("bp_drained", 32'(delivered == accepted), 32'd1);

        // Reset while both stages hold operations.
        req_valid = 4'hF; rsp_ready = 1'b0;
        repeat (2) step();
        chk("mid_full", 32'(obs_busy), 32'd1);
        rst = 1'b1; step();
        rst = 1'b0; req_valid = 4'b0110; rsp_ready = 1'b1;
        step();
        chk("mid_rsp_valid", 32'(obs_rv),   32'd0);
        chk("mid_busy",      32'(obs_busy), 32'd0);
        chk("mid_gnt",       32'(obs_gnt),  32'h2);
        req_valid = 4'b0000;
        repeat (3) step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            rst       = ($urandom_range(63) == 0);
            req_valid = 4'($urandom);
            req_data  = {$urandom, $urandom};
            rsp_ready = ($urandom_range(9) < 7);
            step();
        end

        // Saturation of the narrow counter over 20 accepted requests.
        rst = 1'b1; rsp_ready = 1'b1; step();
        rst = 1'b0; req_valid = 4'hF;
        for (int i = 0; i < 20; i++) begin
            req_data = {$urandom, $urandom};
            step();
        end
        req_valid = 4'b0000;
        repeat (3) step();
        chk("sat_count_15",   32'(obs_cnt_s), 32'd15);
        chk("full_count_20",  32'(obs_cnt),   32'd20);
        chk("sat_delivered",  32'(delivered), 32'd20);
        chk("sat_idle",       32'(obs_busy),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
